adc_frame_scheduler: RTL

//  Single-clock sequencer for the 8-lane 16-bit simultaneous-sampling ADC front end.

---
 rtl/adc_frame_scheduler.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/adc_frame_scheduler.sv
// Purpose: CNV / SCK-gate / bit-index sequencer for an 8-lane 16-bit ADC, paced to a fixed frame period.
// Latency: registered outputs; CNV rises one cycle after EN/START is sampled in IDLE.
// Backpressure: FRAME_READY is sampled as the frame completes; low drops the frame and sets sticky OVERRUN.
module adc_frame_scheduler #(
    parameter int CNV_CYCLES    = 10,
    parameter int ACQ_CYCLES    = 15,
    parameter int NBITS         = 16,
    parameter int PERIOD_CYCLES = 50,
    parameter int WINDOW_FRAMES = 40000,
    localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1
) (
    input  logic          CLK,
    input  logic          RESETN,
    input  logic          EN,
    input  logic          START,
    input  logic          FRAME_READY,
    input  logic          CLR_OVR,
    output logic          CNV,
    output logic          SCK_EN,
    output logic [BW-1:0] BIT_IDX,
    output logic          FRAME_VALID,
    output logic          WINDOW_DONE,
    output logic          BUSY,
    output logic          OVERRUN,
    output logic [15:0]   FRAME_CNT
);

    // A frame cannot be shorter than its own phases plus the DONE cycle.
    localparam int MIN_PERIOD = CNV_CYCLES + ACQ_CYCLES + NBITS + 1;
    localparam int EFF_PERIOD = (PERIOD_CYCLES > MIN_PERIOD) ? PERIOD_CYCLES : MIN_PERIOD;
    localparam int PH_MAX0    = (CNV_CYCLES > ACQ_CYCLES) ? CNV_CYCLES : ACQ_CYCLES;
    localparam int PH_MAX     = (PH_MAX0 > NBITS) ? PH_MAX0 : NBITS;
    localparam int CW         = $clog2(PH_MAX + 1);
    localparam int PW         = $clog2(EFF_PERIOD + 1);
    localparam int WW         = $clog2(WINDOW_FRAMES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CONV, S_ACQ, S_SHIFT, S_DONE, S_GAP
    } state_t;

    state_t        state, nstate;
    logic [CW-1:0] cnt, ncnt;     // cycles spent in the current phase
    logic [PW-1:0] pcnt, npcnt;   // cycles since the current frame started
    logic [WW-1:0] wcnt;          // accepted frames in the open window
    logic          frame_end;
    logic          accept;

    // Phase sequencing and frame pacing.
    always_comb begin
        nstate = state;
        ncnt   = cnt;
        npcnt  = pcnt + PW'(1);
        unique case (state)
            S_IDLE: begin
                npcnt = '0;
                ncnt  = '0;
                if (EN || START) nstate = S_CONV;
            end
            S_CONV: begin
                if (cnt == CW'(CNV_CYCLES - 1)) begin
                    nstate = S_ACQ;
                    ncnt   = '0;
                end else begin
                    ncnt = cnt + CW'(1);
                end
            end
            S_ACQ: begin
                if (cnt == CW'(ACQ_CYCLES - 1)) begin
                    nstate = S_SHIFT;
                    ncnt   = '0;
                end else begin
                    ncnt = cnt + CW'(1);
                end
            end
            S_SHIFT: begin
                if (cnt == CW'(NBITS - 1)) begin
                    nstate = S_DONE;
                    ncnt   = '0;
                end else begin
                    ncnt = cnt + CW'(1);
                end
            end
            S_DONE: begin
                // A stopped run ends right after the handshake; otherwise pace.
                if (!EN) begin
                    nstate = S_IDLE;
                end else if (pcnt == PW'(EFF_PERIOD - 1)) begin
                    nstate = S_CONV;
                    npcnt  = '0;
                end else begin
                    nstate = S_GAP;
                end
            end
            S_GAP: begin
                if (pcnt == PW'(EFF_PERIOD - 1)) begin
                    npcnt  = '0;
                    nstate = EN ? S_CONV : S_IDLE;
                end
            end
            default: nstate = S_IDLE;
        endcase
    end

    // Handshake is taken on the edge that enters DONE so FRAME_VALID lands in DONE.
    assign frame_end = (state == S_SHIFT) && (nstate == S_DONE);
    assign accept    = frame_end && FRAME_READY;

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state       <= S_IDLE;
            cnt         <= '0;
            pcnt        <= '0;
            wcnt        <= '0;
            CNV         <= 1'b0;
            SCK_EN      <= 1'b0;
            BIT_IDX     <= '0;
            FRAME_VALID <= 1'b0;
            WINDOW_DONE <= 1'b0;
            BUSY        <= 1'b0;
            OVERRUN     <= 1'b0;
            FRAME_CNT   <= '0;
        end else begin
            state       <= nstate;
            cnt         <= ncnt;
            pcnt        <= npcnt;
            CNV         <= (nstate == S_CONV);
            SCK_EN      <= (nstate == S_SHIFT);
            BIT_IDX     <= (nstate == S_SHIFT) ? (BW'(NBITS - 1) - BW'(ncnt)) : '0;
            BUSY        <= (nstate != S_IDLE);
            FRAME_VALID <= accept;
            WINDOW_DONE <= accept && (wcnt == WW'(WINDOW_FRAMES - 1));
            if (accept) begin
                FRAME_CNT <= FRAME_CNT + 16'd1;
                wcnt      <= (wcnt == WW'(WINDOW_FRAMES - 1)) ? '0 : wcnt + WW'(1);
            end else if ((nstate == S_IDLE) && (state != S_IDLE)) begin
                wcnt <= '0;   // partial windows are discarded when the run stops
            end
            if (frame_end && !FRAME_READY) begin
                OVERRUN <= 1'b1;
            end else if (CLR_OVR) begin
                OVERRUN <= 1'b0;
            end
        end
    end

endmodule
